// File: rtl/mips_lite_pkg.sv
// Shared definitions for the mips-lite datapath: writeback mux encodings,
// the default register address width and the writeback arbiter state type.
package mips_lite_pkg;

    localparam logic REG_SRC_ALU  = 1'b0;
    localparam logic REG_SRC_DMEM = 1'b1;

    localparam int DEFAULT_RA_W = 3;

    typedef enum logic {
        WB_RUN   = 1'b0,
        WB_BLOCK = 1'b1
    } wb_state_t;

endpackage

// File: rtl/ld_track_pipe.sv
// Delay line following each issued load until its data appears on the DMem
// return bus; the last stage marks the cycle that data is valid.
module ld_track_pipe #(
    parameter int DMEM_LAT = 1,
    parameter int RA_W     = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_v,
    input  logic [RA_W-1:0] i_rd,
    output logic            o_v,
    output logic [RA_W-1:0] o_rd
);

    logic [DMEM_LAT-1:0] r_v;
    logic [RA_W-1:0]     r_rd [DMEM_LAT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v <= '0;
            for (int i = 0; i < DMEM_LAT; i++) begin
                r_rd[i] <= '0;
            end
        end else begin
            r_v[0]  <= i_v;
            r_rd[0] <= i_rd;
            for (int i = 1; i < DMEM_LAT; i++) begin
                r_v[i]  <= r_v[i-1];
                r_rd[i] <= r_rd[i-1];
            end
        end
    end

    assign o_v  = r_v[DMEM_LAT-1];
    assign o_rd = r_rd[DMEM_LAT-1];

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU results and
// fixed-latency load returns, and throttles load issue when the ALU starves.
module wb_port_arbiter
    import mips_lite_pkg::*;
#(
    parameter int RA_W       = DEFAULT_RA_W,
    parameter int DMEM_LAT   = 1,
    parameter int STARVE_MAX = 3,
    parameter bit R0_ZERO    = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_alu_valid,
    input  logic [RA_W-1:0] i_alu_rd,
    output logic            o_alu_ready,
    input  logic            i_ld_issue,
    input  logic [RA_W-1:0] i_ld_rd,
    output logic            o_ld_block,
    output logic            o_reg_src_cntrl,
    output logic            o_reg_we,
    output logic [RA_W-1:0] o_reg_waddr,
    output logic            o_proto_err
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

    wb_state_t        r_state;
    wb_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_proto_err;

    logic             w_ld_track;
    logic             w_ret_v;
    logic [RA_W-1:0]  w_ret_rd;
    logic             w_alu_ready;
    logic             w_alu_blocked;
    logic             w_src;
    logic             w_we;
    logic [RA_W-1:0]  w_waddr;

    assign w_ld_track = i_ld_issue && (r_state != WB_BLOCK);

    ld_track_pipe #(
        .DMEM_LAT (DMEM_LAT),
        .RA_W     (RA_W)
    ) u_ld_track (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_v   (w_ld_track),
        .i_rd  (i_ld_rd),
        .o_v   (w_ret_v),
        .o_rd  (w_ret_rd)
    );

    // A returning load must win: its data exists on the bus for this cycle only.
    always_comb begin
        w_src       = REG_SRC_ALU;
        w_we        = 1'b0;
        w_waddr     = '0;
        w_alu_ready = 1'b0;
        if (!i_rst) begin
            if (w_ret_v) begin
                w_src   = REG_SRC_DMEM;
                w_waddr = w_ret_rd;
                w_we    = !(R0_ZERO && (w_ret_rd == '0));
            end else if (i_alu_valid) begin
                w_src       = REG_SRC_ALU;
                w_waddr     = i_alu_rd;
                w_we        = !(R0_ZERO && (i_alu_rd == '0));
                w_alu_ready = 1'b1;
            end
        end
    end

    assign w_alu_blocked = i_alu_valid && !w_alu_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WB_RUN: begin
                if (w_alu_blocked && (r_starve_cnt == CNT_LAST)) begin
                    w_state_nxt = WB_BLOCK;
                end
            end
            WB_BLOCK: begin
                if (w_alu_ready || !i_alu_valid) begin
                    w_state_nxt = WB_RUN;
                end
            end
            default: w_state_nxt = WB_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= WB_RUN;
            r_starve_cnt <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_alu_blocked) begin
                if (r_starve_cnt != CNT_MAX) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
            if (i_ld_issue && (r_state == WB_BLOCK)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign o_alu_ready     = w_alu_ready;
    assign o_ld_block      = (r_state == WB_BLOCK);
    assign o_reg_src_cntrl = w_src;
    assign o_reg_we        = w_we;
    assign o_reg_waddr     = w_waddr;
    assign o_proto_err     = r_proto_err;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scoreboard bench for wb_port_arbiter (DMEM_LAT=1, STARVE_MAX=3, R0_ZERO=1):
// each driven cycle queues its hand-derived expected outputs, checked at the falling edge.
module tb_wb_port_arbiter;

    logic       clk;
    logic       rst;
    logic       aluValid;
    logic [2:0] aluRd;
    logic       aluReady;
    logic       ldIssue;
    logic [2:0] ldRd;
    logic       ldBlock;
    logic       regSrc;
    logic       regWe;
    logic [2:0] regWaddr;
    logic       protoErr;

    typedef struct {
        logic       src;
        logic       we;
        logic [2:0] waddr;
        logic       rdy;
        logic       blk;
        logic       err;
        int         step;
    } expT;

    expT expQ[$];
    expT monE;
    int  compareCount = 0;
    int  failCount    = 0;
    int  stepNum      = 0;

    wb_port_arbiter #(
        .RA_W       (3),
        .DMEM_LAT   (1),
        .STARVE_MAX (3),
        .R0_ZERO    (1'b1)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_alu_valid     (aluValid),
        .i_alu_rd        (aluRd),
        .o_alu_ready     (aluReady),
        .i_ld_issue      (ldIssue),
        .i_ld_rd         (ldRd),
        .o_ld_block      (ldBlock),
        .o_reg_src_cntrl (regSrc),
        .o_reg_we        (regWe),
        .o_reg_waddr     (regWaddr),
        .o_proto_err     (protoErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compareCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and queues what that cycle must show.
    task automatic applyStimulus(
        input logic r, input logic av, input logic [2:0] ard,
        input logic li, input logic [2:0] lrd,
        input logic es, input logic ewe, input logic [2:0] ewa,
        input logic erdy, input logic eblk, input logic eerr);
        expT e;
        @(posedge clk);
        #1;
        rst      = r;
        aluValid = av;
        aluRd    = ard;
        ldIssue  = li;
        ldRd     = lrd;
        stepNum++;
        e.src   = es;
        e.we    = ewe;
        e.waddr = ewa;
        e.rdy   = erdy;
        e.blk   = eblk;
        e.err   = eerr;
        e.step  = stepNum;
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            checkOutput($sformatf("s%0d reg_src", monE.step),   {7'd0, regSrc},   {7'd0, monE.src});
            checkOutput($sformatf("s%0d reg_we", monE.step),    {7'd0, regWe},    {7'd0, monE.we});
            checkOutput($sformatf("s%0d reg_waddr", monE.step), {5'd0, regWaddr}, {5'd0, monE.waddr});
            checkOutput($sformatf("s%0d alu_ready", monE.step), {7'd0, aluReady}, {7'd0, monE.rdy});
            checkOutput($sformatf("s%0d ld_block", monE.step),  {7'd0, ldBlock},  {7'd0, monE.blk});
            checkOutput($sformatf("s%0d proto_err", monE.step), {7'd0, protoErr}, {7'd0, monE.err});
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        aluValid = 1'b0;
        aluRd    = '0;
        ldIssue  = 1'b0;
        ldRd     = '0;

        //            rst av ard li lrd | src we wa rdy blk err
        applyStimulus(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // plain ALU write
        applyStimulus(0, 1, 5, 0, 0,  0, 1, 5, 1, 0, 0);
        // load return beats a waiting ALU result
        applyStimulus(0, 0, 0, 1, 3,  0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 6, 0, 0,  1, 1, 3, 0, 0, 0);
        applyStimulus(0, 1, 6, 0, 0,  0, 1, 6, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // back-to-back loads starve the ALU until ld_block
        applyStimulus(0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 7, 1, 2,  1, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 7, 1, 3,  1, 1, 2, 0, 0, 0);
        applyStimulus(0, 1, 7, 1, 4,  1, 1, 3, 0, 0, 0);
        applyStimulus(0, 1, 7, 0, 0,  1, 1, 4, 0, 1, 0);
        applyStimulus(0, 1, 7, 0, 0,  0, 1, 7, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // same again, but a load is issued against ld_block
        applyStimulus(0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 7, 1, 2,  1, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 7, 1, 3,  1, 1, 2, 0, 0, 0);
        applyStimulus(0, 1, 7, 1, 4,  1, 1, 3, 0, 0, 0);
        applyStimulus(0, 1, 7, 1, 5,  1, 1, 4, 0, 1, 0);
        applyStimulus(0, 1, 7, 0, 0,  0, 1, 7, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        // ALU write to r0 is consumed without a write enable
        applyStimulus(0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 1);
        // reset lands on the cycle an in-flight load would return
        applyStimulus(0, 0, 0, 1, 6,  0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        // load to r0: port taken, no write enable
        applyStimulus(0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 2, 0, 0,  1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 2, 0, 0,  0, 1, 2, 1, 0, 0);
        // ALU gives up while blocked: back to RUN without a grant
        applyStimulus(0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3, 1, 2,  1, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 3, 1, 3,  1, 1, 2, 0, 0, 0);
        applyStimulus(0, 1, 3, 1, 4,  1, 1, 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0,  1, 1, 4, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        checkOutput("queue_drain", 8'(expQ.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
